// File: rtl/tage_update_ctrl_pkg.sv
// Shared constants and FSM encodings for the TAGE bank update controller.
// The ATTE state exists only when TAGE_ATTE_EN is defined.
package tage_update_ctrl_pkg;

  // Inactive and active levels for strobes and enables.
  localparam logic AbleValue   = 1'b0;
  localparam logic EnableValue = 1'b1;

`ifdef TAGE_ATTE_EN
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StAtte  = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StWrite = 1'b1
  } state_e;
`endif

endpackage

// File: rtl/tage_update_ctrl_if.sv
// Update-request and bank-write bundle for the TAGE update controller.
interface tage_update_ctrl_if #(
  parameter int unsigned TDPW      = 7,
  parameter int unsigned TWIDE     = 9,
  parameter int unsigned COUNTWIDE = 2
);
  logic                       Flush;
  logic                       UpValid;
  logic                       UpReady;
  logic [TDPW-1:0]            UpAddr;
  logic [TWIDE-1:0]           UpTagPt;
  logic                       UpTaken;
  logic                       Wen;
  logic [TDPW-1:0]            Waddr;
  logic [TWIDE+COUNTWIDE-1:0] Din;
  logic                       Atte;

  modport master (
    output Flush, UpValid, UpAddr, UpTagPt, UpTaken,
    input  UpReady, Wen, Waddr, Din, Atte
  );

  modport slave (
    input  Flush, UpValid, UpAddr, UpTagPt, UpTaken,
    output UpReady, Wen, Waddr, Din, Atte
  );
endinterface

// File: rtl/tage_update_fifo.sv
// Small synchronous FIFO holding pending bank updates. Flush wins over push/pop.
// full_next exposes next-cycle fullness so the ready flag can be registered.
module tage_update_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             full_next
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FullCnt);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer and occupancy next state; pointers wrap modulo Depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  assign full_next = (cnt_d == FullCnt);

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care while the occupancy says empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tage_update_ctrl.sv
// TAGE bank update controller: queues resolved-branch updates and streams them
// to the bank write port one per cycle, with registered outputs.
// Build option TAGE_ATTE_EN: every 2^ATTEPW writes, insert one Atte cycle that
// stalls the write stream. Undefined: Atte is tied low and writes never stall.
module tage_update_ctrl
  import tage_update_ctrl_pkg::*;
#(
  parameter int unsigned TDPW      = 7,
  parameter int unsigned TWIDE     = 9,
  parameter int unsigned COUNTWIDE = 2,
  parameter int unsigned FDEEP     = 4,
  parameter int unsigned ATTEPW    = 8
) (
  input logic              Clk,
  input logic              Rest,
  tage_update_ctrl_if.slave up
);
  // Entry = {addr, tag/pointer upper bits, taken}; the low TWIDE bits are the Din payload.
  localparam int unsigned EntW = TDPW + TWIDE;
  localparam int unsigned DinW = TWIDE + COUNTWIDE;

  state_e            state_q, state_d;
  logic              accept, avail, take;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_full_next;
  logic [EntW-1:0]   in_ent, fifo_ent, head_ent;
  logic              ready_q;
  logic              wen_q, wen_d;
  logic [TDPW-1:0]   waddr_q, waddr_d;
  logic [DinW-1:0]   din_q, din_d;
  logic              unused_tag0;

  assign unused_tag0 = up.UpTagPt[0];

  assign accept   = up.UpValid & ready_q & ~up.Flush;
  assign in_ent   = {up.UpAddr, up.UpTagPt[TWIDE-1:1], up.UpTaken};
  // An empty FIFO lets a just-accepted update go straight to the write registers.
  assign avail    = ~fifo_empty | accept;
  assign head_ent = fifo_empty ? in_ent : fifo_ent;
  assign take     = (state_d == StWrite);

  assign fifo_pop  = take & ~fifo_empty;
  assign fifo_push = accept & ~fifo_full & ~(take & fifo_empty);

  tage_update_fifo #(
    .Width (EntW),
    .Depth (FDEEP)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (Rest),
    .flush     (up.Flush),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .wdata     (in_ent),
    .rdata     (fifo_ent),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .full_next (fifo_full_next)
  );

`ifdef TAGE_ATTE_EN
  logic [ATTEPW-1:0] acnt_q;
  logic              atte_q, atte_d;
  logic              wrap;

  assign wrap = (state_q == StWrite) && (acnt_q == '1);

  // Write counter: advances on every cycle that carries a bank write.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      acnt_q <= '0;
    end else if (state_q == StWrite) begin
      acnt_q <= acnt_q + 1'b1;
    end
  end
`else
  localparam int unsigned unused_attepw = ATTEPW;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: write whenever something is pending unless flushed or attenuating.
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle: begin
        state_d = (avail && !up.Flush) ? StWrite : StIdle;
      end
      StWrite: begin
        state_d = (avail && !up.Flush) ? StWrite : StIdle;
`ifdef TAGE_ATTE_EN
        // The counter wrap still earns its Atte cycle even under Flush.
        if (wrap) state_d = StAtte;
`endif
      end
`ifdef TAGE_ATTE_EN
      StAtte: begin
        state_d = (avail && !up.Flush) ? StWrite : StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output next values; address and data hold whenever no write is issued.
  always_comb begin
    wen_d   = AbleValue;
    waddr_d = waddr_q;
    din_d   = din_q;
    if (take) begin
      wen_d   = EnableValue;
      waddr_d = head_ent[EntW-1 -: TDPW];
      din_d   = {{COUNTWIDE{1'b0}}, head_ent[TWIDE-1:0]};
    end
`ifdef TAGE_ATTE_EN
    atte_d = (state_d == StAtte) ? EnableValue : AbleValue;
`endif
  end

  // Output registers; UpReady reflects next-cycle occupancy so it is not a comb path.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      wen_q   <= AbleValue;
      waddr_q <= '0;
      din_q   <= '0;
      ready_q <= AbleValue;
`ifdef TAGE_ATTE_EN
      atte_q  <= AbleValue;
`endif
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      ready_q <= ~fifo_full_next;
`ifdef TAGE_ATTE_EN
      atte_q  <= atte_d;
`endif
    end
  end

  assign up.UpReady = ready_q;
  assign up.Wen     = wen_q;
  assign up.Waddr   = waddr_q;
  assign up.Din     = din_q;
`ifdef TAGE_ATTE_EN
  assign up.Atte    = atte_q;
`else
  assign up.Atte    = AbleValue;
`endif

endmodule

// File: tb/tb_tage_update_ctrl.sv
// Self-checking bench for tage_update_ctrl: a queue-based reference model is
// compared with the DUT every cycle, plus hand-computed literal expectations.
// Honours TAGE_ATTE_EN the same way the design does.
module tb_tage_update_ctrl;
  localparam int unsigned TDPW      = 7;
  localparam int unsigned TWIDE     = 9;
  localparam int unsigned COUNTWIDE = 2;
  localparam int unsigned FDEEP     = 4;
  localparam int unsigned ATTEPW    = 8;
  localparam int unsigned DinW      = TWIDE + COUNTWIDE;
  localparam int unsigned Period    = 1 << ATTEPW;
  localparam int unsigned NStream   = 520;
`ifdef TAGE_ATTE_EN
  localparam bit AttEn = 1'b1;
`else
  localparam bit AttEn = 1'b0;
`endif

  logic Clk  = 1'b0;
  logic Rest = 1'b0;
  always #5 Clk = ~Clk;

  tage_update_ctrl_if #(.TDPW(TDPW), .TWIDE(TWIDE), .COUNTWIDE(COUNTWIDE)) bus ();

  tage_update_ctrl #(
    .TDPW      (TDPW),
    .TWIDE     (TWIDE),
    .COUNTWIDE (COUNTWIDE),
    .FDEEP     (FDEEP),
    .ATTEPW    (ATTEPW)
  ) dut (
    .Clk  (Clk),
    .Rest (Rest),
    .up   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted update waits in a queue and is written
  // the cycle after it becomes the oldest, except during attenuation cycles.
  typedef struct {
    logic [TDPW-1:0] addr;
    logic [DinW-1:0] din;
  } ent_t;

  ent_t            mq[$];
  ent_t            me;
  logic            m_wen   = 1'b0;
  logic            m_atte  = 1'b0;
  logic            m_ready = 1'b0;
  logic [TDPW-1:0] m_waddr = '0;
  logic [DinW-1:0] m_din   = '0;
  int              m_writes = 0;
  bit              m_acc, m_atn;

  always @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      mq.delete();
      m_wen = 1'b0; m_atte = 1'b0; m_ready = 1'b0;
      m_waddr = '0; m_din = '0; m_writes = 0;
    end else begin
      m_acc = bus.UpValid && m_ready && !bus.Flush;
      if (m_acc) begin
        me.addr = bus.UpAddr;
        me.din  = {{COUNTWIDE{1'b0}}, bus.UpTagPt[TWIDE-1:1], bus.UpTaken};
        mq.push_back(me);
      end
      if (m_wen) m_writes++;
      m_atn = AttEn && m_wen && (m_writes % Period == 0);
      if (bus.Flush) mq.delete();
      m_atte = m_atn;
      m_wen  = 1'b0;
      if (!m_atn && mq.size() > 0) begin
        me = mq.pop_front();
        m_wen = 1'b1; m_waddr = me.addr; m_din = me.din;
      end
      m_ready = (mq.size() < FDEEP);
    end
  end

  // Per-cycle comparison and a log of observed writes/attenuation pulses.
  logic [TDPW-1:0] obs_addr[$];
  int obs_atte_at[$];
  int cyc_n = 0;
  int first_wen = -1;
  int last_wen  = -1;

  always @(negedge Clk) begin
    cyc_n++;
    if (Rest) begin
      check("wen",   32'(bus.Wen),     32'(m_wen));
      check("atte",  32'(bus.Atte),    32'(m_atte));
      check("ready", 32'(bus.UpReady), 32'(m_ready));
      check("waddr", 32'(bus.Waddr),   32'(m_waddr));
      check("din",   32'(bus.Din),     32'(m_din));
      if (bus.Wen) begin
        obs_addr.push_back(bus.Waddr);
        if (first_wen < 0) first_wen = cyc_n;
        last_wen = cyc_n;
      end
      if (bus.Atte) obs_atte_at.push_back(obs_addr.size());
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    bus.UpValid = 1'b0;
    bus.Flush   = 1'b0;
    bus.UpAddr  = '0;
    bus.UpTagPt = '0;
    bus.UpTaken = 1'b0;
  endtask

  task automatic drive(input logic [TDPW-1:0] a, input logic [TWIDE-1:0] t, input logic k);
    bus.UpValid = 1'b1;
    bus.UpAddr  = a;
    bus.UpTagPt = t;
    bus.UpTaken = k;
  endtask

  task automatic clear_log();
    obs_addr.delete();
    obs_atte_at.delete();
    first_wen = -1;
    last_wen  = -1;
  endtask

  int i;

  initial begin
    idle_in();
    #2;
    check("reset_wen",   32'(bus.Wen),     32'h0);
    check("reset_atte",  32'(bus.Atte),    32'h0);
    check("reset_ready", 32'(bus.UpReady), 32'h0);
    check("reset_waddr", 32'(bus.Waddr),   32'h0);
    check("reset_din",   32'(bus.Din),     32'h0);

    @(negedge Clk);
    Rest = 1'b1;
    step();
    check("ready_after_release", 32'(bus.UpReady), 32'h1);
    repeat (2) step();

    // Single update: written the cycle after acceptance.
    drive(7'h25, 9'h1A3, 1'b1);
    step();
    idle_in();
    check("single_wen",   32'(bus.Wen),   32'h1);
    check("single_waddr", 32'(bus.Waddr), 32'h25);
    check("single_din",   32'(bus.Din),   32'h1A3);
    step();
    check("single_done_wen",  32'(bus.Wen), 32'h0);
    check("single_hold_addr", 32'(bus.Waddr), 32'h25);
    repeat (2) step();

    // Six back-to-back updates: all written in order with no gaps.
    clear_log();
    for (int k = 0; k < 6; k++) begin
      drive(TDPW'(8'h10 + k), TWIDE'(9'h040 + 35 * k), k[0]);
      step();
    end
    idle_in();
    repeat (4) step();
    check("burst_count", 32'(obs_addr.size()), 32'd6);
    check("burst_span",  32'(last_wen - first_wen + 1), 32'd6);
    if (obs_addr.size() == 6) begin
      for (int k = 0; k < 6; k++) check("burst_order", 32'(obs_addr[k]), 32'h10 + k);
    end

    // Flush with UpValid high: no further writes, ready next cycle, last update dropped.
    clear_log();
    drive(7'h30, 9'h011, 1'b0); step();
    drive(7'h31, 9'h022, 1'b1); step();
    drive(7'h32, 9'h033, 1'b1); bus.Flush = 1'b1; step();
    idle_in();
    check("flush_wen",   32'(bus.Wen),     32'h0);
    check("flush_ready", 32'(bus.UpReady), 32'h1);
    repeat (3) step();
    check("flush_writes", 32'(obs_addr.size()), 32'd2);

    // Asynchronous reset in the middle of a burst.
    for (int k = 0; k < 3; k++) begin
      drive(TDPW'(8'h40 + k), 9'h1FF, 1'b1);
      step();
    end
    #2;
    Rest = 1'b0;
    idle_in();
    #1;
    check("midrst_wen",   32'(bus.Wen),     32'h0);
    check("midrst_atte",  32'(bus.Atte),    32'h0);
    check("midrst_ready", 32'(bus.UpReady), 32'h0);
    check("midrst_waddr", 32'(bus.Waddr),   32'h0);
    check("midrst_din",   32'(bus.Din),     32'h0);
    @(negedge Clk);
    Rest = 1'b1;
    clear_log();
    step();
    check("rerelease_ready", 32'(bus.UpReady), 32'h1);

    // First update after reset, immediately followed by a long stream.
    drive(7'h55, 9'h0AA, 1'b0);
    step();
    check("post_rst_wen",   32'(bus.Wen),   32'h1);
    check("post_rst_waddr", 32'(bus.Waddr), 32'h55);
    check("post_rst_din",   32'(bus.Din),   32'h0AA);
    for (i = 0; i < NStream; i++) begin
      drive(TDPW'(i), TWIDE'(i * 37), i[0]);
      step();
    end
    idle_in();
    repeat (6) step();

    check("stream_writes", 32'(obs_addr.size()), 32'(NStream + 1));
    if (obs_addr.size() == NStream + 1) begin
      check("stream_first", 32'(obs_addr[0]),       32'h55);
      check("stream_last",  32'(obs_addr[NStream]), 32'h07);
    end
`ifdef TAGE_ATTE_EN
    check("atte_pulses", 32'(obs_atte_at.size()), 32'd2);
    if (obs_atte_at.size() == 2) begin
      check("atte_after_256", 32'(obs_atte_at[0]), 32'd256);
      check("atte_after_512", 32'(obs_atte_at[1]), 32'd512);
    end
    check("stream_span", 32'(last_wen - first_wen + 1), 32'(NStream + 1 + 2));
`else
    check("atte_pulses", 32'(obs_atte_at.size()), 32'd0);
    check("stream_span", 32'(last_wen - first_wen + 1), 32'(NStream + 1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tage_update_ctrl.md
TAGE_UPDATE_CTRL -- requirements
Module: tage_update_ctrl

Interface
REQ-001 SHALL have parameters: TDPW, default 7, bank address width; TWIDE, default 9, tag/pointer width; COUNTWIDE, default 2, counter width; FDEEP, default 4, update FIFO depth; ATTEPW, default 8, attenuation period width (period = 2^ATTEPW writes).
REQ-002 SHALL have port Clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port Rest  input  1  asynchronous active-low reset.
REQ-004 SHALL have port Flush  input  1  drop all queued updates.
REQ-005 SHALL have port UpValid  input  1  resolved-branch update offered.
REQ-006 SHALL have port UpReady  output  1  update can be accepted.
REQ-007 SHALL have port UpAddr  input  TDPW  bank entry to update.
REQ-008 SHALL have port UpTagPt  input  TWIDE  tag/pointer field.
REQ-009 SHALL have port UpTaken  input  1  resolved direction (1 = prediction right/taken).
REQ-010 SHALL have port Wen  output  1  bank write strobe.
REQ-011 SHALL have port Waddr  output  TDPW  bank write address.
REQ-012 SHALL have port Din  output  TWIDE+COUNTWIDE  bank write data.
REQ-013 SHALL have port Atte  output  1  counter attenuation strobe.

Function
REQ-014 SHALL buffer accepted updates in an FDEEP-entry FIFO; accept when UpValid && UpReady.
REQ-015 SHALL drive UpReady = FIFO not full, from registered occupancy; no full-FIFO bypass (push refused when full even if a pop occurs that cycle).
REQ-016 SHALL wrap read/write pointers modulo FDEEP; occupancy width clog2(FDEEP)+1.
REQ-017 SHALL use FSM states IDLE, WRITE, ATTE: IDLE->WRITE when FIFO non-empty; WRITE stays while non-empty, ->IDLE when empty; WRITE->ATTE on the write that wraps the attenuation counter; ATTE->WRITE/IDLE after one cycle.
REQ-018 SHALL register all outputs: update accepted into empty FIFO in cycle N -> Wen=1 in cycle N+1; sustained throughput one write per cycle.
REQ-019 SHALL pack Din = {COUNTWIDE zeros, UpTagPt[TWIDE-1:1], UpTaken}; Waddr = UpAddr of popped entry.
REQ-020 SHALL drive Wen=0 and hold Waddr/Din at last values in IDLE and ATTE.
REQ-021 SHALL increment an ATTEPW-bit write counter on every Wen=1 cycle; on wrap 2^ATTEPW-1 -> 0, assert Atte=1 for exactly the next cycle with Wen=0 and FIFO pop stalled; pushes continue.
REQ-022 SHALL on Flush empty the FIFO next edge, suppress Wen from the next cycle, drop a same-cycle UpValid, and not alter the attenuation counter; Flush during ATTE still completes the Atte pulse.
REQ-023 SHALL treat simultaneous push and pop in a non-full FIFO as occupancy unchanged.

Reset
REQ-024 SHALL on Rest=0 asynchronously clear FIFO, pointers, attenuation counter, FSM to IDLE; Wen=0, Waddr=0, Din=0, Atte=0, UpReady=0.
REQ-025 SHALL drive UpReady=1 from the first rising edge after Rest deasserts; reset mid-write aborts the write (Wen=0 immediately).

Configuration
REQ-026 SHALL honour macro TAGE_ATTE_EN: defined -> REQ-021 attenuation behaviour and ATTE state present; undefined -> Atte tied 0, no write counter, no ATTE state, writes never stalled.

Structure
REQ-027 SHALL take enable/disable level constants (AbleValue/EnableValue) and FSM state encodings from the shared define.v package.
REQ-028 SHALL place the FIFO in one sub-module tage_update_fifo (parameters width, depth; push/pop/full/empty/flush).

Verification
REQ-029 SHALL cover: single update UpAddr=7'h25, UpTagPt=9'h1A3, UpTaken=1 in cycle 5 -> Wen=1 cycle 6, Waddr=7'h25, Din=11'h1A3.
REQ-030 SHALL cover: 6 back-to-back updates, no stall -> UpReady=0 once 4 queued, 6 consecutive-or-gap-free writes in order, none lost.
REQ-031 SHALL cover: 256 writes (ATTEPW=8, TAGE_ATTE_EN defined) -> Atte=1 one cycle after 256th Wen, Wen=0 that cycle, 257th write follows next cycle.
REQ-032 SHALL cover: Flush with 3 queued and UpValid=1 -> no further Wen, UpReady=1 next cycle, occupancy 0.
REQ-033 SHALL cover: Rest=0 mid-burst -> all outputs 0 asynchronously; after release, first new update written with REQ-018 latency.
REQ-034 SHALL cover: TAGE_ATTE_EN undefined, 512 writes -> Atte never asserted, no write gaps.
